// File: rtl/sym_feeder_if.sv
// sym_feeder_if: producer-side symbol handshake into sym_feeder.
//
// Handshake: in_valid/in_sym are driven by the producer and in_ready by the
// feeder. A symbol moves exactly at a rising clock edge where both in_valid
// and in_ready are high. The producer must hold in_sym stable while in_valid
// is high and not yet accepted. in_ready does not depend on in_valid.
//
// Signals:
//   in_sym   [1:0]  symbol from the producer
//   in_valid        in_sym holds a symbol this cycle
//   in_ready        feeder can take a symbol at the next edge
interface sym_feeder_if;
  logic [1:0] in_sym;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_sym,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_sym,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/sym_feeder.sv
// sym_feeder: buffers 2-bit symbols from a producer in a small circular FIFO
// and presents each one on x_out for HOLD cycles, followed by GAP cycles of
// IDLE_SYM. x_out only changes at the rising clock edge, so the downstream
// recognizer never sees a mid-cycle input change.
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   prod       producer handshake (slave side of sym_feeder_if)
//   flush      synchronous: drop FIFO contents and abort the current symbol
//   x_out      registered symbol to the recognizer
//   x_stb      one-cycle pulse in the first cycle of each presented symbol
//   busy       FSM not idle or FIFO not empty
//   level      FIFO occupancy
//   dbg_state  current FSM state (0 idle, 1 show, 2 gap)
module sym_feeder #(
  parameter int         DEPTH    = 4,
  parameter int         HOLD     = 1,
  parameter int         GAP      = 0,
  parameter logic [1:0] IDLE_SYM = 2'b00,
  localparam int        LW       = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset_n,
  sym_feeder_if.slave     prod,
  input  logic            flush,
  output logic [1:0]      x_out,
  output logic            x_stb,
  output logic            busy,
  output logic [LW-1:0]   level,
  output logic [1:0]      dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // FIFO storage and bookkeeping
  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;

  // Presentation FSM
  state_e        state_q, state_d;
  logic [1:0]    x_q, x_d;
  logic          stb_q, stb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       slot_end;
  logic [1:0] head;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Held low during reset so nothing is offered to a FIFO that is being cleared.
  assign prod.in_ready = reset_n & ~full;

  // Fullness is judged on the registered count, so a pop at the same edge
  // never opens room for a push. flush drops any push at its edge.
  assign push = prod.in_valid & prod.in_ready & ~flush;

  // slot_end marks the edge at which a new symbol may be loaded: from idle,
  // at the end of the hold phase when there is no gap, or at the end of the gap.
  always_comb begin
    slot_end = 1'b0;
    case (state_q)
      ST_IDLE: slot_end = 1'b1;
      ST_SHOW: slot_end = (hold_q == '0) && (GAP == 0);
      ST_GAP:  slot_end = (gap_q == '0);
      default: slot_end = 1'b0;
    endcase
  end

  assign pop = slot_end & ~empty & ~flush;

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + LW'(push) - LW'(pop);
    end
  end

  // Presentation FSM next-state / next-output
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    stb_d   = 1'b0;
    hold_d  = hold_q;
    gap_d   = gap_q;
    if (flush) begin
      state_d = ST_IDLE;
      x_d     = IDLE_SYM;
      hold_d  = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          x_d = IDLE_SYM;
          if (pop) begin
            x_d     = head;
            stb_d   = 1'b1;
            hold_d  = HW'(HOLD - 1);
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
          end else if (GAP > 0) begin
            x_d     = IDLE_SYM;
            gap_d   = GW'(GAP - 1);
            state_d = ST_GAP;
          end else if (pop) begin
            // Back-to-back load; equal symbols leave x_out unchanged but
            // still produce a fresh strobe.
            x_d    = head;
            stb_d  = 1'b1;
            hold_d = HW'(HOLD - 1);
          end else begin
            x_d     = IDLE_SYM;
            state_d = ST_IDLE;
          end
        end
        ST_GAP: begin
          x_d = IDLE_SYM;
          if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
          end else if (pop) begin
            x_d     = head;
            stb_d   = 1'b1;
            hold_d  = HW'(HOLD - 1);
            state_d = ST_SHOW;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          x_d     = IDLE_SYM;
          hold_d  = '0;
          gap_d   = '0;
        end
      endcase
    end
  end

  // FIFO storage has no reset; only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= prod.in_sym;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      x_q      <= IDLE_SYM;
      stb_q    <= 1'b0;
      hold_q   <= '0;
      gap_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      x_q      <= x_d;
      stb_q    <= stb_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
    end
  end

  assign x_out     = x_q;
  assign x_stb     = stb_q;
  assign level     = count_q;
  assign busy      = (state_q != ST_IDLE) | ~empty;
  assign dbg_state = state_q;

endmodule
